// File: rtl/simt_stack_multi.sv
// Per-warp SIMT reconvergence stack with push/pop/peek/flush and sticky errors.
// Optional high-water output guarded by SIMT_STACK_HIGH_WATER_EN.
module simt_stack_multi #(
  parameter int NUM_WARPS = 32,
  parameter int THREADS   = 32,
  parameter int DEPTH     = 16,
  parameter int PC_W      = 32,
  localparam int WID_W    = $clog2(NUM_WARPS),
  localparam int OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [1:0]         op_code,
  input  logic [WID_W-1:0]   op_warp,
  input  logic [THREADS-1:0] push_mask,
  input  logic [PC_W-1:0]    push_pc,
  input  logic [PC_W-1:0]    push_rpc,
  input  logic               flush_all,
  output logic               resp_valid,
  output logic [WID_W-1:0]   resp_warp,
  output logic [THREADS-1:0] resp_mask,
  output logic [PC_W-1:0]    resp_pc,
  output logic [PC_W-1:0]    resp_rpc,
  output logic               resp_empty,
  input  logic [WID_W-1:0]   occ_warp,
  output logic [OCC_W-1:0]   occ,
  input  logic               err_clr,
  output logic [31:0]        err
`ifdef SIMT_STACK_HIGH_WATER_EN
  ,output logic [OCC_W-1:0]  hw
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WID_W:0] NW = (WID_W+1)'(NUM_WARPS);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] ONE = OCC_W'(1);

  typedef enum logic [1:0] {
    OP_PUSH  = 2'd0,
    OP_POP   = 2'd1,
    OP_PEEK  = 2'd2,
    OP_FLUSH = 2'd3
  } op_e;

  typedef struct packed {
    logic [THREADS-1:0] mask;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    rpc;
  } entry_t;

  entry_t           mem [NUM_WARPS][DEPTH];
  logic [OCC_W-1:0] sp  [NUM_WARPS];
  logic             ovf_q, unf_q;

  op_e              op;
  logic             op_in, occ_in, op_ok;
  logic [OCC_W-1:0] cur_sp;
  logic             full, empty;
  logic [AW-1:0]    top_idx, wr_idx;
  entry_t           top;
  logic             is_push, is_pop, is_peek, is_flush;
  logic             do_push, do_pop, do_flush, rd, ovf, unf;

  assign op      = op_e'(op_code);
  assign op_in   = {1'b0, op_warp} < NW;
  assign occ_in  = {1'b0, occ_warp} < NW;
  assign op_ok   = op_valid && op_in && !flush_all;
  assign cur_sp  = op_in ? sp[op_warp] : '0;
  assign full    = cur_sp == FULL;
  assign empty   = cur_sp == '0;
  assign top_idx = AW'(cur_sp - ONE);
  assign wr_idx  = AW'(cur_sp);
  assign top     = mem[op_warp][top_idx];

  always_comb begin
    is_push  = 1'b0;
    is_pop   = 1'b0;
    is_peek  = 1'b0;
    is_flush = 1'b0;
    unique case (op)
      OP_PUSH:  is_push  = 1'b1;
      OP_POP:   is_pop   = 1'b1;
      OP_PEEK:  is_peek  = 1'b1;
      OP_FLUSH: is_flush = 1'b1;
    endcase
  end

  assign do_push  = op_ok && is_push && !full;
  assign ovf      = op_ok && is_push && full;
  assign do_pop   = op_ok && is_pop && !empty;
  assign unf      = op_ok && is_pop && empty;
  assign do_flush = op_ok && is_flush;
  assign rd       = op_ok && (is_pop || is_peek);

  // Entry storage is intentionally left unreset; sp alone defines validity.
  always_ff @(posedge clk) begin
    if (!rst && do_push)
      mem[op_warp][wr_idx] <= {push_mask, push_pc, push_rpc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) sp[w] <= '0;
      resp_valid <= 1'b0;
      resp_warp  <= '0;
      resp_mask  <= '0;
      resp_pc    <= '0;
      resp_rpc   <= '0;
      resp_empty <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      resp_valid <= rd;
      if (rd) begin
        resp_warp  <= op_warp;
        resp_empty <= empty;
        {resp_mask, resp_pc, resp_rpc} <= empty ? '0 : top;
      end
      if (flush_all) begin
        for (int w = 0; w < NUM_WARPS; w++) sp[w] <= '0;
      end else if (do_push) begin
        sp[op_warp] <= cur_sp + ONE;
      end else if (do_pop) begin
        sp[op_warp] <= cur_sp - ONE;
      end else if (do_flush) begin
        sp[op_warp] <= '0;
      end
      ovf_q <= ovf || (ovf_q && !err_clr);
      unf_q <= unf || (unf_q && !err_clr);
    end
  end

  assign occ = occ_in ? sp[occ_warp] : '0;
  assign err = {25'b0, unf_q, ovf_q, 5'b0};

`ifdef SIMT_STACK_HIGH_WATER_EN
  logic [OCC_W-1:0] hwm [NUM_WARPS];

  // Per-warp FLUSH deliberately keeps the mark; only flush_all clears it.
  always_ff @(posedge clk) begin
    if (rst || flush_all) begin
      for (int w = 0; w < NUM_WARPS; w++) hwm[w] <= '0;
    end else if (do_push && (cur_sp + ONE) > hwm[op_warp]) begin
      hwm[op_warp] <= cur_sp + ONE;
    end
  end

  assign hw = occ_in ? hwm[occ_warp] : '0;
`endif

endmodule

// File: tb/tb_simt_stack_multi.sv
// Randomised and directed bench for simt_stack_multi against a queue model.
// Checks hw as well when SIMT_STACK_HIGH_WATER_EN is defined.
module tb_simt_stack_multi;
  localparam int NW = 32;
  localparam int TH = 32;
  localparam int D  = 16;
  localparam int PW = 32;
  localparam int WW = 5;
  localparam int OW = 5;

  logic          clk = 1'b0;
  logic          rst, op_valid, flush_all, err_clr;
  logic [1:0]    op_code;
  logic [WW-1:0] op_warp, occ_warp, resp_warp;
  logic [TH-1:0] push_mask, resp_mask;
  logic [PW-1:0] push_pc, push_rpc, resp_pc, resp_rpc;
  logic          resp_valid, resp_empty;
  logic [OW-1:0] occ;
  logic [31:0]   err;
`ifdef SIMT_STACK_HIGH_WATER_EN
  logic [OW-1:0] hw;
`endif

  always #5 clk = ~clk;

  simt_stack_multi dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .op_warp(op_warp), .push_mask(push_mask), .push_pc(push_pc),
    .push_rpc(push_rpc), .flush_all(flush_all),
    .resp_valid(resp_valid), .resp_warp(resp_warp),
    .resp_mask(resp_mask), .resp_pc(resp_pc), .resp_rpc(resp_rpc),
    .resp_empty(resp_empty), .occ_warp(occ_warp), .occ(occ),
    .err_clr(err_clr), .err(err)
`ifdef SIMT_STACK_HIGH_WATER_EN
    ,.hw(hw)
`endif
  );

  typedef struct packed {
    logic [TH-1:0] m;
    logic [PW-1:0] pc;
    logic [PW-1:0] rpc;
  } ent_t;

  int checks = 0;
  int errors = 0;

  ent_t          mq [NW][$];
  int            mhw [NW];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  logic          e_rv, e_empty;
  ent_t          e_dat;
  logic [WW-1:0] e_warp;

  function automatic logic [31:0] m_err();
    return {25'b0, m_unf, m_ovf, 5'b0};
  endfunction

  function automatic ent_t rnd_ent();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  function automatic ent_t mk(input logic [TH-1:0] m, input logic [PW-1:0] pc,
                              input logic [PW-1:0] rpc);
    return {m, pc, rpc};
  endfunction

  // Drives one cycle and advances the queue model by the same rules.
  task automatic apply(input logic r, input logic v, input logic [1:0] c,
                       input int w, input ent_t d, input logic fa,
                       input logic ec);
    logic ov, un;
    ov = 1'b0;
    un = 1'b0;
    rst = r; op_valid = v; op_code = c; op_warp = w[WW-1:0];
    push_mask = d.m; push_pc = d.pc; push_rpc = d.rpc;
    flush_all = fa; err_clr = ec;
    e_rv = 1'b0; e_empty = 1'b0; e_dat = '0; e_warp = w[WW-1:0];
    if (r) begin
      for (int i = 0; i < NW; i++) begin
        mq[i].delete();
        mhw[i] = 0;
      end
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (fa) begin
        for (int i = 0; i < NW; i++) begin
          mq[i].delete();
          mhw[i] = 0;
        end
      end else if (v && w < NW) begin
        case (c)
          2'd0: begin
            if (mq[w].size() < D) begin
              mq[w].push_back(d);
              if (mq[w].size() > mhw[w]) mhw[w] = mq[w].size();
            end else ov = 1'b1;
          end
          2'd1: begin
            e_rv = 1'b1;
            if (mq[w].size() > 0) e_dat = mq[w].pop_back();
            else begin e_empty = 1'b1; un = 1'b1; end
          end
          2'd2: begin
            e_rv = 1'b1;
            if (mq[w].size() > 0) e_dat = mq[w][$];
            else e_empty = 1'b1;
          end
          default: mq[w].delete();
        endcase
      end
      m_ovf = ov | (m_ovf & ~ec);
      m_unf = un | (m_unf & ~ec);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; op_valid = 1'b0; flush_all = 1'b0; err_clr = 1'b0;
  endtask

  task automatic idle(input logic ec);
    apply(1'b0, 1'b0, 2'd0, 0, '0, 1'b0, ec);
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b0, 2'd0, 0, '0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 2'd0, 0, '0, 1'b0, 1'b0);
    checks++;
    if (resp_valid !== 1'b0) begin errors++;
      $display("FAIL reset_rv got %b want 0", resp_valid); end
    checks++;
    if (err !== 32'h0) begin errors++;
      $display("FAIL reset_err got %h want 0", err); end
    checks++;
    if ({resp_mask, resp_pc, resp_rpc, resp_empty} !== '0) begin errors++;
      $display("FAIL reset_resp got %h/%h/%h", resp_mask, resp_pc, resp_rpc); end
    for (int w = 0; w < NW; w += 7) begin
      occ_warp = w[WW-1:0];
      #1;
      checks++;
      if (occ !== '0) begin errors++;
        $display("FAIL reset_occ w%0d got %0d want 0", w, occ); end
    end
  endtask

  task automatic test_push_pop();
    apply(1'b0, 1'b1, 2'd0, 3, mk(32'h0000FFFF, 32'h100, 32'h200), 1'b0, 1'b0);
    apply(1'b0, 1'b1, 2'd1, 3, '0, 1'b0, 1'b0);
    occ_warp = 5'd3;
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_warp !== 5'd3 || resp_empty !== 1'b0)
    begin errors++;
      $display("FAIL pp_ctl got v%b w%0d e%b want v1 w3 e0",
               resp_valid, resp_warp, resp_empty); end
    checks++;
    if (resp_mask !== 32'h0000FFFF || resp_pc !== 32'h100 ||
        resp_rpc !== 32'h200) begin errors++;
      $display("FAIL pp_data got %h/%h/%h want 0000ffff/100/200",
               resp_mask, resp_pc, resp_rpc); end
    checks++;
    if (occ !== 5'd0) begin errors++;
      $display("FAIL pp_occ got %0d want 0", occ); end
    idle(1'b0);
    checks++;
    if (resp_valid !== 1'b0) begin errors++;
      $display("FAIL pp_pulse got %b want 0", resp_valid); end
  endtask

  task automatic test_overflow();
    ent_t v [D];
    for (int i = 0; i < D; i++) begin
      v[i] = rnd_ent();
      apply(1'b0, 1'b1, 2'd0, 0, v[i], 1'b0, 1'b0);
    end
    checks++;
    if (err !== 32'h0) begin errors++;
      $display("FAIL ovf_early got %h want 0", err); end
    apply(1'b0, 1'b1, 2'd0, 0, rnd_ent(), 1'b0, 1'b0);
    occ_warp = 5'd0;
    #1;
    checks++;
    if (occ !== 5'd16) begin errors++;
      $display("FAIL ovf_occ got %0d want 16", occ); end
    checks++;
    if (err !== 32'h20) begin errors++;
      $display("FAIL ovf_err got %h want 20", err); end
    apply(1'b0, 1'b1, 2'd1, 0, '0, 1'b0, 1'b0);
    checks++;
    if (resp_valid !== 1'b1 || {resp_mask, resp_pc, resp_rpc} !== v[D-1])
    begin errors++;
      $display("FAIL ovf_pop got v%b %h want %h", resp_valid,
               {resp_mask, resp_pc, resp_rpc}, v[D-1]); end
    apply(1'b0, 1'b1, 2'd3, 0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_underflow();
    apply(1'b0, 1'b1, 2'd1, 5, '0, 1'b0, 1'b0);
    checks++;
    if (resp_valid !== 1'b1 || resp_empty !== 1'b1 ||
        {resp_mask, resp_pc, resp_rpc} !== '0) begin errors++;
      $display("FAIL unf_pop got v%b e%b %h want v1 e1 0", resp_valid,
               resp_empty, {resp_mask, resp_pc, resp_rpc}); end
    checks++;
    if (err !== 32'h40) begin errors++;
      $display("FAIL unf_err got %h want 40", err); end
    idle(1'b1);
    apply(1'b0, 1'b1, 2'd2, 5, '0, 1'b0, 1'b0);
    checks++;
    if (resp_valid !== 1'b1 || resp_empty !== 1'b1) begin errors++;
      $display("FAIL unf_peek got v%b e%b want v1 e1", resp_valid, resp_empty); end
    checks++;
    if (err !== 32'h0) begin errors++;
      $display("FAIL unf_peek_err got %h want 0", err); end
  endtask

  task automatic test_peek_flush();
    apply(1'b0, 1'b1, 2'd0, 2, rnd_ent(), 1'b0, 1'b0);
    apply(1'b0, 1'b1, 2'd0, 1, mk('1, 32'hA, 32'h0), 1'b0, 1'b0);
    apply(1'b0, 1'b1, 2'd0, 1, mk('1, 32'hB, 32'h0), 1'b0, 1'b0);
    apply(1'b0, 1'b1, 2'd2, 1, '0, 1'b0, 1'b0);
    occ_warp = 5'd1;
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_pc !== 32'hB) begin errors++;
      $display("FAIL peek_pc got v%b %h want v1 b", resp_valid, resp_pc); end
    checks++;
    if (occ !== 5'd2) begin errors++;
      $display("FAIL peek_occ got %0d want 2", occ); end
    apply(1'b0, 1'b1, 2'd3, 1, '0, 1'b0, 1'b0);
    checks++;
    if (occ !== 5'd0 || resp_valid !== 1'b0) begin errors++;
      $display("FAIL flush_occ got %0d v%b want 0 v0", occ, resp_valid); end
    occ_warp = 5'd2;
    #1;
    checks++;
    if (occ !== 5'd1) begin errors++;
      $display("FAIL flush_other got %0d want 1", occ); end
    apply(1'b0, 1'b1, 2'd3, 2, '0, 1'b0, 1'b0);
  endtask

  task automatic test_flush_all();
    apply(1'b0, 1'b1, 2'd0, 4, rnd_ent(), 1'b0, 1'b0);
    apply(1'b0, 1'b1, 2'd0, 9, rnd_ent(), 1'b0, 1'b0);
    apply(1'b0, 1'b1, 2'd1, 7, '0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 2'd1, 4, '0, 1'b1, 1'b0);
    checks++;
    if (resp_valid !== 1'b0) begin errors++;
      $display("FAIL fa_rv got %b want 0", resp_valid); end
    checks++;
    if (err !== 32'h40) begin errors++;
      $display("FAIL fa_err got %h want 40", err); end
    for (int w = 0; w < NW; w++) begin
      occ_warp = w[WW-1:0];
      #1;
      checks++;
      if (occ !== '0) begin errors++;
        $display("FAIL fa_occ w%0d got %0d want 0", w, occ); end
    end
    idle(1'b1);
  endtask

  task automatic test_set_wins();
    for (int i = 0; i < D + 1; i++)
      apply(1'b0, 1'b1, 2'd0, 6, rnd_ent(), 1'b0, 1'b0);
    apply(1'b0, 1'b1, 2'd0, 6, rnd_ent(), 1'b0, 1'b1);
    checks++;
    if (err !== 32'h20) begin errors++;
      $display("FAIL set_wins got %h want 20", err); end
    idle(1'b1);
    checks++;
    if (err !== 32'h0) begin errors++;
      $display("FAIL err_clr got %h want 0", err); end
    apply(1'b0, 1'b0, 2'd0, 0, '0, 1'b1, 1'b0);
  endtask

`ifdef SIMT_STACK_HIGH_WATER_EN
  task automatic test_high_water();
    for (int i = 0; i < 3; i++)
      apply(1'b0, 1'b1, 2'd0, 9, rnd_ent(), 1'b0, 1'b0);
    apply(1'b0, 1'b1, 2'd1, 9, '0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 2'd1, 9, '0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 2'd3, 9, '0, 1'b0, 1'b0);
    occ_warp = 5'd9;
    #1;
    checks++;
    if (hw !== 5'd3 || occ !== 5'd0) begin errors++;
      $display("FAIL hw got %0d occ %0d want 3 0", hw, occ); end
    apply(1'b0, 1'b0, 2'd0, 0, '0, 1'b1, 1'b0);
    checks++;
    if (hw !== 5'd0) begin errors++;
      $display("FAIL hw_fa got %0d want 0", hw); end
  endtask
`endif

  task automatic test_reset_mid();
    apply(1'b0, 1'b1, 2'd0, 8, rnd_ent(), 1'b0, 1'b0);
    apply(1'b0, 1'b1, 2'd0, 8, rnd_ent(), 1'b0, 1'b0);
    apply(1'b1, 1'b1, 2'd1, 8, '0, 1'b0, 1'b0);
    occ_warp = 5'd8;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || occ !== 5'd0) begin errors++;
      $display("FAIL rst_mid got v%b occ %0d want v0 0", resp_valid, occ); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      int w, pick;
      logic [1:0] c;
      logic v, fa, ec;
      w = ($urandom_range(0, 9) == 0) ? $urandom_range(0, NW - 1)
                                        : $urandom_range(0, 3);
      pick = $urandom_range(0, 99);
      c = (pick < 50) ? 2'd0 : (pick < 75) ? 2'd1 : (pick < 95) ? 2'd2 : 2'd3;
      v = $urandom_range(0, 9) != 0;
      fa = $urandom_range(0, 199) == 0;
      ec = $urandom_range(0, 7) == 0;
      occ_warp = 5'($urandom_range(0, 4));
      apply(1'b0, v, c, w, rnd_ent(), fa, ec);
      checks++;
      if (resp_valid !== e_rv) begin errors++;
        $display("FAIL rnd_rv @%0d got %b want %b", n, resp_valid, e_rv); end
      if (e_rv) begin
        checks++;
        if (resp_warp !== e_warp || resp_empty !== e_empty ||
            {resp_mask, resp_pc, resp_rpc} !== e_dat) begin errors++;
          $display("FAIL rnd_resp @%0d got w%0d e%b %h want w%0d e%b %h", n,
                   resp_warp, resp_empty, {resp_mask, resp_pc, resp_rpc},
                   e_warp, e_empty, e_dat); end
      end
      checks++;
      if (err !== m_err()) begin errors++;
        $display("FAIL rnd_err @%0d got %h want %h", n, err, m_err()); end
      checks++;
      if (occ !== OW'(mq[occ_warp].size())) begin errors++;
        $display("FAIL rnd_occ @%0d w%0d got %0d want %0d", n, occ_warp,
                 occ, mq[occ_warp].size()); end
`ifdef SIMT_STACK_HIGH_WATER_EN
      checks++;
      if (hw !== OW'(mhw[occ_warp])) begin errors++;
        $display("FAIL rnd_hw @%0d got %0d want %0d", n, hw, mhw[occ_warp]); end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_code = 2'd0; op_warp = '0;
    push_mask = '0; push_pc = '0; push_rpc = '0;
    flush_all = 1'b0; err_clr = 1'b0; occ_warp = '0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_peek_flush();
    test_flush_all();
    test_set_wins();
`ifdef SIMT_STACK_HIGH_WATER_EN
    test_high_water();
`endif
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/simt_stack_multi.md
Name: simt_stack_multi

Overview:
Parametrised per-warp SIMT reconvergence stack. It replaces the fixed 16-entry single-depth stack with one configurable stack per warp, plus peek, per-warp flush and global flush. It sits between the branch unit and the fetcher: the branch unit issues push, pop, peek and flush ops, and the fetcher consumes the registered pop and peek responses (mask, PC, reconvergence PC). Overflow and underflow are reported on the SP error-word bits.

Parameters:
NUM_WARPS, 32, number of warps; warp id width is WID_W = $clog2(NUM_WARPS).
THREADS, 32, threads per warp; active-mask width.
DEPTH, 16, entries per warp stack; must be at least 2.
PC_W, 32, PC width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
op_valid  in  1  op request
op_code  in  2  0=PUSH, 1=POP, 2=PEEK, 3=FLUSH (clear this warp)
op_warp  in  WID_W  target warp
push_mask  in  THREADS  mask to store
push_pc  in  PC_W  next PC to store
push_rpc  in  PC_W  reconvergence PC to store
flush_all  in  1  clear every warp's stack
resp_valid  out  1  one-cycle pulse; response to a POP or PEEK
resp_warp  out  WID_W  warp of the response
resp_mask  out  THREADS  popped/peeked mask
resp_pc  out  PC_W  popped/peeked next PC
resp_rpc  out  PC_W  popped/peeked reconvergence PC
resp_empty  out  1  stack was empty; data fields are 0
occ_warp  in  WID_W  occupancy query warp
occ  out  $clog2(DEPTH+1)  occupancy of occ_warp (combinational from state)
err_clr  in  1  clear sticky error
err  out  32  sticky error word; bit5 = overflow, bit6 = underflow

Behaviour:
- Storage: NUM_WARPS x DEPTH entries of {mask, pc, rpc}. Each warp has a stack pointer sp[w] in the range 0..DEPTH. Ops are accepted every cycle (no ready signal); at most one op per cycle.
- Reset: all sp = 0, resp_valid = 0, resp_* = 0, err = 0. Entry contents are not reset.
- PUSH, sp < DEPTH: write entry[w][sp]; sp++. No response.
- PUSH, sp == DEPTH: no write, sp unchanged; set err bit5.
- POP, sp > 0: next cycle resp_valid = 1 with the data of entry[w][sp-1] and resp_empty = 0; sp--.
- POP, sp == 0: next cycle resp_valid = 1, resp_empty = 1, data = 0; set err bit6; sp unchanged.
- PEEK: same as POP, but sp is never modified and an empty stack never sets the error bit.
- FLUSH: sp[w] = 0. No response.
- Latency: POP/PEEK response is exactly 1 cycle after op_valid. occ reflects state updated at the clock edge, so a PUSH in cycle N is visible on occ in cycle N+1.
- flush_all: all sp = 0 next cycle. It wins over a simultaneous op; that op is dropped and produces no response and no error.
- Back-to-back: a POP in cycle N+1 sees the PUSH of cycle N (pointer and entry already written). A PUSH then POP to the same warp returns the pushed data.
- Error word: err bits set on error events and stay set until err_clr. err_clr together with a new error event in the same cycle leaves the bit set (set wins). All other err bits read 0.
- Reset asserted mid-sequence: sp cleared; no response from an op presented in the reset cycle.
- Warps are fully independent; there is no cross-warp pointer interaction.
- op_warp >= NUM_WARPS (non-power-of-2 counts): op ignored; sets no error bit.

Optional Feature:
SIMT_STACK_HIGH_WATER_EN
- Defined: adds output hw of width $clog2(DEPTH+1). It reports the maximum sp reached by occ_warp since reset or since the last flush_all. It updates on PUSH only, and a per-warp FLUSH does not clear it.
- Undefined: port absent; no high-water registers are synthesised.

Test Plan:
- PUSH warp 3 {mask=0x0000FFFF, pc=0x100, rpc=0x200}, then POP warp 3 -> next cycle resp_valid=1, resp_warp=3, mask=0x0000FFFF, pc=0x100, rpc=0x200, resp_empty=0; occ(3)=0.
- 16 PUSHes to warp 0 (DEPTH=16), then a 17th -> occ(0)=16, err=0x20, entry 15 intact; POP returns the 16th pushed value.
- POP on empty warp 5 -> resp_valid=1, resp_empty=1, data 0, err=0x40; PEEK on empty warp 5 after err_clr -> resp_empty=1, err=0.
- PUSH warp 1 twice (pc=0xA, 0xB), PEEK -> pc=0xB with occ(1) still 2; FLUSH warp 1 -> occ(1)=0; warp 2 occupancy unaffected.
- POP warp 4 coincident with flush_all -> no resp_valid, all occ=0, err unchanged.
- Overflow event in the same cycle as err_clr -> err bit5 = 1 afterwards; with SIMT_STACK_HIGH_WATER_EN, push 3 / pop 2 / FLUSH -> hw=3.
